// File: rtl/elliptic_curve_structs.sv
// Shared ECDSA datapath types: curve constants and the multiplier-arbiter state encoding.
package elliptic_curve_structs;

    typedef struct packed {
        logic [255:0] p;
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] n;
    } curve_parameters_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        CAPT
    } mult_arb_state_t;

    localparam int MULT_ARB_DEFAULT_TIMEOUT = 2048;

endpackage

// File: rtl/mult_n_arbiter_if.sv
// Requester-side bus of the shared multiplier arbiter; master = requesters, slave = arbiter.
interface mult_n_arbiter_if
    import elliptic_curve_structs::*;
#(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0][255:0] op_a;
    logic [NUM_REQ-1:0][255:0] op_b;
    curve_parameters_t         params;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [255:0]              result;
    logic                      busy;
    logic                      err;

    modport master (output req, op_a, op_b, params, input gnt, done, result, busy, err);
    modport slave  (input req, op_a, op_b, params, output gnt, done, result, busy, err);
endinterface

// File: rtl/mult_n_arbiter_rr_pick.sv
// Combinational round-robin pick: lowest set request at or above the pointer, else lowest overall.
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);
    logic [NUM_REQ-1:0] w_upper;
    logic [NUM_REQ-1:0] w_cand;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
        assign w_upper[gi] = i_req[gi] && (IDX_W'(gi) >= i_ptr);
    end

    assign w_cand = (|w_upper) ? w_upper : i_req;
    assign o_any  = |i_req;

    // Scan high to low so the lowest candidate wins.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_cand[k]) begin
                o_onehot    = '0;
                o_onehot[k] = 1'b1;
                o_idx       = IDX_W'(k);
            end
        end
    end
endmodule

// File: rtl/mult_n_arbiter.sv
// Round-robin sharing of one multiplier_n between NUM_REQ requesters, one operation in flight.
// Optional watchdog in RUN enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_n_arbiter
    import elliptic_curve_structs::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int IDX_W       = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYC = MULT_ARB_DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              Reset,
    mult_n_arbiter_if.slave   bus,
    output logic              mul_reset,
    output logic [255:0]      mul_a,
    output logic [255:0]      mul_b,
    output curve_parameters_t mul_params,
    input  logic              mul_done,
    input  logic [255:0]      mul_product
);
    mult_arb_state_t   r_state, w_state_next;
    logic [IDX_W-1:0]  r_ptr, w_ptr_next;
    logic [IDX_W-1:0]  r_sel, w_sel_next;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_next;
    logic [NUM_REQ-1:0] r_done, w_done_next;
    logic [255:0]      r_result, w_result_next;
    logic              r_busy, w_busy_next;
    logic [255:0]      r_mul_a, w_mul_a_next;
    logic [255:0]      r_mul_b, w_mul_b_next;
    curve_parameters_t r_mul_params, w_mul_params_next;

    logic [NUM_REQ-1:0] w_pick_onehot;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic [NUM_REQ-1:0] w_sel_onehot;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_err, w_err_next;
`endif

    rr_priority_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
        assign w_sel_onehot[gi] = (r_sel == IDX_W'(gi));
    end

    always_comb begin
        w_state_next      = r_state;
        w_ptr_next        = r_ptr;
        w_sel_next        = r_sel;
        w_gnt_next        = '0;
        w_done_next       = '0;
        w_result_next     = r_result;
        w_busy_next       = r_busy;
        w_mul_a_next      = r_mul_a;
        w_mul_b_next      = r_mul_b;
        w_mul_params_next = r_mul_params;
`ifdef MULT_ARB_TIMEOUT_EN
        w_cnt_next        = r_cnt;
        w_err_next        = r_err;
`endif
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_sel_next        = w_pick_idx;
                    w_gnt_next        = w_pick_onehot;
                    w_mul_a_next      = bus.op_a[w_pick_idx];
                    w_mul_b_next      = bus.op_b[w_pick_idx];
                    w_mul_params_next = bus.params;
                    w_busy_next       = 1'b1;
                    w_state_next      = LOAD;
                end
            end
            LOAD: begin
                w_state_next = RUN;
`ifdef MULT_ARB_TIMEOUT_EN
                w_cnt_next   = '0;
`endif
            end
            RUN: begin
                // done/result are registered on leaving RUN so they are valid throughout CAPT.
                if (mul_done) begin
                    w_result_next = mul_product;
                    w_done_next   = w_sel_onehot;
                    w_busy_next   = 1'b0;
                    w_state_next  = CAPT;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_result_next = '0;
                    w_done_next   = w_sel_onehot;
                    w_busy_next   = 1'b0;
                    w_err_next    = 1'b1;
                    w_state_next  = CAPT;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
`endif
            end
            CAPT: begin
                w_ptr_next   = (r_sel == IDX_W'(NUM_REQ - 1)) ? '0 : r_sel + 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_sel        <= '0;
            r_gnt        <= '0;
            r_done       <= '0;
            r_result     <= '0;
            r_busy       <= 1'b0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_mul_params <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            r_cnt        <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_ptr        <= w_ptr_next;
            r_sel        <= w_sel_next;
            r_gnt        <= w_gnt_next;
            r_done       <= w_done_next;
            r_result     <= w_result_next;
            r_busy       <= w_busy_next;
            r_mul_a      <= w_mul_a_next;
            r_mul_b      <= w_mul_b_next;
            r_mul_params <= w_mul_params_next;
`ifdef MULT_ARB_TIMEOUT_EN
            r_cnt        <= w_cnt_next;
            r_err        <= w_err_next;
`endif
        end
    end

    // The multiplier only runs in RUN; everywhere else it is held in Init.
    assign mul_reset   = (r_state != RUN);
    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign mul_params  = r_mul_params;
    assign bus.gnt     = r_gnt;
    assign bus.done    = r_done;
    assign bus.result  = r_result;
    assign bus.busy    = r_busy;
`ifdef MULT_ARB_TIMEOUT_EN
    assign bus.err     = r_err;
`else
    assign bus.err     = 1'b0;
`endif
endmodule

// File: tb/tb_mult_n_arbiter.sv
// Scoreboard bench for mult_n_arbiter with a behavioural multiplier_n stub (fixed latency).
module tb_mult_n_arbiter;
    import elliptic_curve_structs::*;

    localparam int NUM_REQ = 4;
    localparam int MUL_LAT = 5;
    localparam int TO_CYC  = 16;
    localparam logic [255:0] N_K1 = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;

    logic clk = 1'b0;
    logic Reset = 1'b1;
    always #5 clk = ~clk;

    mult_n_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    logic              mul_reset, mul_done;
    logic [255:0]      mul_a, mul_b, mul_product;
    curve_parameters_t mul_params;

    mult_n_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .bus         (bus),
        .mul_reset   (mul_reset),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_params  (mul_params),
        .mul_done    (mul_done),
        .mul_product (mul_product)
    );

    function automatic logic [255:0] modmul(input logic [255:0] a, input logic [255:0] b, input logic [255:0] n);
        logic [511:0] p;
        p = {256'd0, a} * {256'd0, b};
        return 256'(p % {256'd0, n});
    endfunction

    // Multiplier stub: samples operands while held in reset, raises Done MUL_LAT cycles after release.
    logic [255:0] m_a, m_b, m_n;
    int           m_cnt;
    logic         m_done;
    logic         stall = 1'b0;
    int           unstable_cnt = 0;
    always @(posedge clk) begin
        if (mul_reset) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_a    <= mul_a;
            m_b    <= mul_b;
            m_n    <= mul_params.n;
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == MUL_LAT && !stall) m_done <= 1'b1;
            if (mul_a !== m_a || mul_b !== m_b) unstable_cnt <= unstable_cnt + 1;
        end
    end
    assign mul_done    = m_done;
    assign mul_product = modmul(m_a, m_b, m_n);

    typedef struct {
        int           idx;
        logic [255:0] res;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    int   n_vec = 0;
    int   n_err = 0;
    int   low_cnt = 0;
    logic exp_err = 1'b0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: invariants plus scoreboard pop on every done pulse.
    always @(negedge clk) begin
        if (!Reset) begin
            if (bus.gnt != 0 || bus.done != 0)
                check_eq("one_hot_excl", 256'($countones({bus.gnt, bus.done})), 256'd1);
            if (!mul_reset) begin
                low_cnt = low_cnt + 1;
                check_eq("busy_in_run", bus.busy, 1'b1);
            end
            if (bus.done != 0) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_done", bus.done, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    $display("done idx=%0d result=0x%0h", mon_e.idx, bus.result);
                    check_eq("done_idx", bus.done, 256'(1 << mon_e.idx));
                    check_eq("result", bus.result, mon_e.res);
                    check_eq("err_at_done", bus.err, exp_err);
                    check_eq("operands_stable", 256'(unstable_cnt), 0);
                end
            end
        end
    end

    // Waits (bounded) for a gnt or done pulse; returns its index and the cycles waited.
    task automatic wait_evt(input bit want_done, output int idx, output int cyc);
        logic [NUM_REQ-1:0] v;
        logic seen;
        idx  = -1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            v = want_done ? bus.done : bus.gnt;
            for (int k = 0; k < NUM_REQ; k++) if (v[k]) idx = k;
            seen = (v != 0);
        end
        if (!seen) check_eq(want_done ? "wait_done_bound" : "wait_gnt_bound", seen, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int idx, cyc, low0;
        bus.req    = '0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.params = '0;
        Reset      = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_gnt", bus.gnt, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_result", bus.result, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_err", bus.err, 0);
        check_eq("rst_mul_reset", mul_reset, 1);
        check_eq("rst_mul_a", mul_a, 0);
        check_eq("rst_mul_b", mul_b, 0);
        Reset = 1'b0;

        // Single request, small modulus.
        bus.params.n = 256'd97;
        bus.op_a[0]  = 256'd3;
        bus.op_b[0]  = 256'd5;
        sb_q.push_back('{idx: 0, res: 256'd15});
        low0    = low_cnt;
        bus.req = 4'b0001;
        wait_evt(1'b0, idx, cyc);
        check_eq("t1_gnt_idx", 256'(idx), 0);
        check_eq("t1_gnt_lat", 256'(cyc), 1);
        bus.op_a[0] = '1;
        wait_evt(1'b1, idx, cyc);
        bus.req = '0;
        check_eq("t1_done_lat", 256'(cyc), 256'(2 + MUL_LAT));
        check_eq("t1_run_cycles", 256'(low_cnt - low0), 256'(MUL_LAT + 1));
        repeat (2) @(negedge clk);
        check_eq("t1_result_hold", bus.result, 256'd15);
        check_eq("t1_idle_mul_reset", mul_reset, 1);

        // Wrap-around operands on the secp256k1 order.
        bus.params.n = N_K1;
        bus.op_a[3]  = N_K1 - 1;
        bus.op_b[3]  = N_K1 - 1;
        sb_q.push_back('{idx: 3, res: 256'd1});
        bus.req = 4'b1000;
        wait_evt(1'b0, idx, cyc);
        check_eq("t2_gnt_idx", 256'(idx), 3);
        bus.op_a[3]  = '0;
        bus.op_b[3]  = '0;
        bus.params.n = 256'd97;
        wait_evt(1'b1, idx, cyc);
        bus.req = '0;

        // Contention: all requesters held, pointer starts at 0.
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.op_a[i] = 256'(i + 2);
            bus.op_b[i] = 256'(i + 20);
        end
        for (int k = 0; k < 5; k++)
            sb_q.push_back('{idx: k % 4, res: 256'((((k % 4) + 2) * ((k % 4) + 20)) % 97)});
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_evt(1'b1, idx, cyc);
            check_eq("t3_order", 256'(idx), 256'(k % 4));
        end
        bus.req = '0;

        // Pointer fairness: serve 2, then 0 and 2 together -> 0 first.
        sb_q.push_back('{idx: 2, res: 256'd88});
        bus.req = 4'b0100;
        wait_evt(1'b1, idx, cyc);
        bus.req = '0;
        @(negedge clk);
        sb_q.push_back('{idx: 0, res: 256'd40});
        sb_q.push_back('{idx: 2, res: 256'd88});
        bus.req = 4'b0101;
        wait_evt(1'b1, idx, cyc);
        check_eq("t4_first", 256'(idx), 0);
        if (idx >= 0) bus.req[idx] = 1'b0;
        wait_evt(1'b1, idx, cyc);
        check_eq("t4_second", 256'(idx), 2);
        bus.req = '0;

        // Reset while in RUN: no done, pointer back to 0.
        bus.op_a[3] = 256'd50;
        bus.op_b[3] = 256'd60;
        bus.req     = 4'b1000;
        wait_evt(1'b0, idx, cyc);
        bus.req = '0;
        repeat (3) @(negedge clk);
        check_eq("t5_in_run", mul_reset, 0);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        check_eq("t5_mul_reset", mul_reset, 1);
        check_eq("t5_busy", bus.busy, 0);
        check_eq("t5_done", bus.done, 0);
        repeat (12) @(negedge clk);
        bus.op_a[1] = 256'd7;
        bus.op_b[1] = 256'd11;
        bus.op_a[3] = 256'd9;
        bus.op_b[3] = 256'd9;
        sb_q.push_back('{idx: 1, res: 256'd77});
        sb_q.push_back('{idx: 3, res: 256'd81});
        bus.req = 4'b1010;
        wait_evt(1'b1, idx, cyc);
        check_eq("t5_first", 256'(idx), 1);
        bus.req[1] = 1'b0;
        wait_evt(1'b1, idx, cyc);
        bus.req = '0;

`ifdef MULT_ARB_TIMEOUT_EN
        // Watchdog: stalled multiplier produces done with result 0 and sticky err.
        stall   = 1'b1;
        exp_err = 1'b1;
        sb_q.push_back('{idx: 0, res: 256'd0});
        bus.req = 4'b0001;
        wait_evt(1'b0, idx, cyc);
        wait_evt(1'b1, idx, cyc);
        bus.req = '0;
        stall   = 1'b0;
        check_eq("t6_timeout_lat", 256'(cyc), 256'(1 + TO_CYC));
        repeat (3) @(negedge clk);
        check_eq("t6_err_sticky", bus.err, 1);
        Reset = 1'b1;
        @(negedge clk);
        Reset   = 1'b0;
        exp_err = 1'b0;
        check_eq("t6_err_cleared", bus.err, 0);
`else
        check_eq("err_tied_low", bus.err, 0);
`endif

        repeat (3) @(negedge clk);
        check_eq("sb_empty", 256'(sb_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mult_n_arbiter.md
Name: mult_n_arbiter

Overview:
- Shares one multiplier_n instance (a·b mod n, shift-and-add) between NUM_REQ requesters in the ECDSA datapath, e.g. the r·d, k⁻¹·(z+rd) and inversion-chain steps.
- Sequences the multiplier's Reset/Done protocol: latches operands, holds them stable for the whole operation, captures the product and returns it to the granted requester.
- Fair round-robin arbitration, one operation in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- IDX_W, $clog2(NUM_REQ), width of requester index
- TIMEOUT_CYC, 2048, watchdog limit in cycles (used only with MULT_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  request level per requester; held until matching done pulse
- op_a  in  NUM_REQ×256  operand a per requester
- op_b  in  NUM_REQ×256  operand b per requester
- params  in  curve_parameters_t  curve constants; only .n used downstream
- gnt  out  NUM_REQ  one-hot grant, 1-cycle pulse when operands are latched
- done  out  NUM_REQ  one-hot, 1-cycle pulse when result is valid
- result  out  256  product, valid in the done cycle, held until the next capture
- busy  out  1  high from grant until done
- err  out  1  timeout sticky flag; tied 0 without MULT_ARB_TIMEOUT_EN
- mul_reset  out  1  drives multiplier_n Reset
- mul_a, mul_b  out  256  registered operands to the multiplier
- mul_params  out  curve_parameters_t  registered copy of params
- mul_done  in  1  multiplier_n Done (level)
- mul_product  in  256  multiplier_n product

Behaviour:
- Reset values: gnt=0, done=0, result=0, busy=0, err=0, mul_reset=1, mul_a=mul_b=0, RR pointer=0, state IDLE.
- States:
  - IDLE: mul_reset=1. If any req is set, select the first set bit at or after the pointer (wrapping), then latch op_a/op_b/params of that index into mul_a/mul_b/mul_params, pulse gnt[i], set busy, go to LOAD.
  - LOAD: one cycle, mul_reset=1 with operands stable, so the multiplier's Init samples them. Go to RUN.
  - RUN: mul_reset=0. mul_a/mul_b stay constant, because the multiplier reads a[0] directly in Start. Wait for mul_done=1, then go to CAPT.
  - CAPT: result<=mul_product, done[i]=1, busy=0, mul_reset=1, pointer<=(i+1) mod NUM_REQ. Go to IDLE.
- Latency: req seen in IDLE at cycle t → gnt at t+1 → done at t+3+L, where L is the multiplier latency from Reset deassertion.
- Minimum back-to-back spacing is 4 cycles plus L. A req still set during the CAPT cycle is eligible in the next IDLE.
- Input rules:
  - req changes during service are ignored and requests cannot be cancelled.
  - op_a/op_b may change after gnt.
  - A requester that drops req still receives its done pulse.
- Simultaneous requests: strict round-robin from the pointer. All NUM_REQ asserted continuously are served 0,1,2,3,0,…
- Reset mid-operation: immediate return to IDLE with mul_reset=1. No done is issued and the pointer goes to 0; requesters must re-request.
- Invariants: gnt and done are never multi-hot, and never asserted in the same cycle.

Optional Feature:
- Macro: MULT_ARB_TIMEOUT_EN
- With the macro:
  - A cycle counter runs in RUN.
  - If it reaches TIMEOUT_CYC without mul_done, set err (sticky until Reset), pulse done[i] with result=0, and return to IDLE via CAPT.
- Without the macro: no counter, err is constantly 0, and RUN waits indefinitely.

Decomposition:
- Shared package elliptic_curve_structs holds:
  - curve_parameters_t (existing)
  - a new enum mult_arb_state_t {IDLE, LOAD, RUN, CAPT}
  - the constant MULT_ARB_DEFAULT_TIMEOUT = 2048
- One sub-module, rr_priority_pick: combinational. Inputs req vector and pointer; outputs one-hot winner, index and any.

Test Plan:
- Single request: req[0] with a=3, b=5, small n=97 → gnt[0] one cycle later, then done[0] with result=15. mul_reset is low only during RUN.
- Wrap-around operands: n=secp256k1 order, a=b=n-1 → result=1. mul_a/mul_b stay constant throughout RUN.
- Contention: req=4'b1111 held continuously → done order 0,1,2,3,0. No overlap between grants.
- Pointer fairness: after serving 2, set req=4'b0101 → grant 0 before 2.
- Reset mid-operation: assert Reset for 1 cycle in RUN → no done, mul_reset=1, state IDLE. A re-request of a=7, b=11 then completes with result 77 (n=97 → 77).
- Timeout (with MULT_ARB_TIMEOUT_EN, TIMEOUT_CYC=16): stub mul_done=0 → done pulse after 16 RUN cycles, result=0, err=1 and stays 1 until Reset.
